sd_spi_master: RTL and testbench
================================

// Module: sd_spi_master
// PURPOSE
//  CPU-side SPI master that drives the emulated SD card's SPI pins (sd_cs, sd_sck, sd_sdi, sd_sdo).
//  The host CPU (BBC user-port / MMC interface) writes a byte, and the block shifts it out MSB-first in SPI mode 0.
//  It captures the byte returned on sd_sdo at the same time and exposes it with a busy flag.
//  The block sits between the core's CPU bus decode and the sd_card SPI slave.
// PARAMETERS
//  DIV_RESET  8'd7  reset value of the divider register; SCK half-period = (div+1) clk_sys cycles
//  DIV_MIN    8'd2  divider values below this are clamped to DIV_MIN (card needs >=3 clk per half-period)
// PORTS
//  clk_sys   in   1  system clock; all logic is on the rising edge
//  reset     in   1  synchronous, active-high
//  cpu_sel   in   1  register access strobe, one clk_sys cycle per access
//  cpu_we    in   1  1 = write, 0 = read (qualified by cpu_sel)
//  cpu_addr  in   2  0 = DATA, 1 = CTRL/STATUS, 2 = DIV, 3 = reserved (reads 8'hff, writes ignored)
//  cpu_din   in   8  write data
//  cpu_dout  out  8  read data, combinational from the registers selected by cpu_addr
//  sd_cs     out  1  chip select, active low
//  sd_sck    out  1  SPI clock, idle low
//  sd_sdi    out  1  MOSI to the card
//  sd_sdo    in   1  MISO from the card
// BEHAVIOUR
//  Reset values:
//   sd_cs=1, sd_sck=0, sd_sdi=1.
//   rx=8'hff, busy=0, ovr=0, div=DIV_RESET, state IDLE.
//   Reset mid-transfer aborts the transfer immediately and applies the same values.
//  Registers:
//   DATA write: loads tx and starts a transfer (only if not busy).
//   DATA read: returns rx, the last completed received byte.
//   CTRL write: bit0 sets cs_n, which drives sd_cs directly; bit6 written 1 clears ovr.
//   STATUS read: {busy, ovr, 5'b0, cs_n}.
//   DIV r/w: 8 bits. The effective divider is max(div, DIV_MIN); it is sampled at the start of each half-period.
//  FSM states: IDLE, LOW, HIGH. The half-period counter hc counts from 0 to div_eff.
//   IDLE + DATA write:
//    sdi <= tx[7], busy <= 1, bit <= 7, hc <= 0, go to LOW.
//   LOW (sck=0):
//    When hc == div_eff: sck <= 1, hc <= 0, go to HIGH.
//   HIGH (sck=1):
//    When hc == div_eff: shift sr <= {sr[6:0], sd_sdo} (sample in the last HIGH cycle), then sck <= 0.
//    If bit == 0: rx <= shifted sr, busy <= 0, sdi <= 1, go to IDLE.
//    Else: bit--, sdi <= next tx bit, go to LOW.
//  sdi changes only together with the sck falling edge, or on transfer start while sck=0. It is always stable across the rising edge.
//  Transfer latency:
//   Exactly 16*(div_eff+1) clk_sys cycles from the DATA write cycle until busy drops.
//   rx is valid in the same cycle busy reads 0.
//  Boundary conditions:
//   DATA write while busy: ignored (tx, transfer and rx untouched), ovr <= 1 (sticky).
//   CTRL write while busy: ignored, ovr <= 1. cs_n never changes mid-byte.
//   DIV write while busy: accepted; takes effect at the next half-period start.
//   DATA read during a transfer: returns the previous rx.
//   Transfers run regardless of sd_cs. With cs_n=1 the card ignores the traffic (dummy clocks for init).
//   ovr set and clear in the same cycle: the set wins.
// TESTING
//  1. Reset: assert reset 1 cycle mid-transfer -> next cycle sd_cs=1, sd_sck=0, sd_sdi=1, STATUS=8'h01, DATA=8'hff.
//  2. Loopback (sd_sdo=sd_sdi), div=7: write 8'ha5 -> 8 sck pulses, each 8 cycles high and 8 cycles low; busy for exactly 128 cycles; DATA reads 8'ha5.
//  3. With the sd_card model, CTRL=0, send 40 00 00 00 00 95 then ff bytes -> the 5th ff byte reads 8'h01 (CMD0 R1 after NCR).
//  4. Write div=0 -> clamped; half-period 3 cycles; transfer takes 48 cycles; DIV reads back 8'h00.
//  5. Write 8'h12, then write DATA 8'h34 and CTRL 8'h00 during busy -> rx=8'h12, sd_cs stays 1, STATUS bit6=1; CTRL write 8'h41 -> ovr cleared, cs still 1.
//  6. Idle check: with no DATA write for 1000 cycles -> sd_sck never toggles and sd_sdi stays 1.

Source files
------------

// File: rtl/sd_spi_master.sv
// SPI mode-0 master for the emulated SD card: CPU writes a byte, it is shifted out MSB-first
// while the returned byte is captured; DATA/CTRL-STATUS/DIV registers on a small CPU bus.
module sd_spi_master #(
  parameter logic [7:0] DIV_RESET = 8'd7,
  parameter logic [7:0] DIV_MIN   = 8'd2
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       cpu_sel,
  input  logic       cpu_we,
  input  logic [1:0] cpu_addr,
  input  logic [7:0] cpu_din,
  output logic [7:0] cpu_dout,
  output logic       sd_cs,
  output logic       sd_sck,
  output logic       sd_sdi,
  input  logic       sd_sdo
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

  state_t     state_reg, state_next;
  logic [7:0] sr_reg, sr_next;
  logic [7:0] rx_reg, rx_next;
  logic [7:0] div_reg, div_next;
  logic [7:0] hc_reg, hc_next;
  logic [7:0] hp_div_reg, hp_div_next;
  logic [2:0] bit_reg, bit_next;
  logic       cs_n_reg, cs_n_next;
  logic       sck_reg, sck_next;
  logic       sdi_reg, sdi_next;
  logic       ovr_reg, ovr_next;

  logic       busy;
  logic [7:0] div_eff;
  logic       wr_data, wr_ctrl, wr_div;

  assign busy    = (state_reg != IDLE);
  assign div_eff = (div_reg < DIV_MIN) ? DIV_MIN : div_reg;
  assign wr_data = cpu_sel && cpu_we && (cpu_addr == 2'd0);
  assign wr_ctrl = cpu_sel && cpu_we && (cpu_addr == 2'd1);
  assign wr_div  = cpu_sel && cpu_we && (cpu_addr == 2'd2);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_reg  <= IDLE;
      sr_reg     <= 8'h00;
      rx_reg     <= 8'hff;
      div_reg    <= DIV_RESET;
      hc_reg     <= 8'h00;
      hp_div_reg <= DIV_RESET;
      bit_reg    <= 3'd0;
      cs_n_reg   <= 1'b1;
      sck_reg    <= 1'b0;
      sdi_reg    <= 1'b1;
      ovr_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      sr_reg     <= sr_next;
      rx_reg     <= rx_next;
      div_reg    <= div_next;
      hc_reg     <= hc_next;
      hp_div_reg <= hp_div_next;
      bit_reg    <= bit_next;
      cs_n_reg   <= cs_n_next;
      sck_reg    <= sck_next;
      sdi_reg    <= sdi_next;
      ovr_reg    <= ovr_next;
    end
  end

  // hp_div_reg holds the divider latched at each half-period start, so DIV writes
  // made mid-transfer only affect the following half-period.
  always_comb begin
    state_next  = state_reg;
    sr_next     = sr_reg;
    rx_next     = rx_reg;
    div_next    = div_reg;
    hc_next     = hc_reg;
    hp_div_next = hp_div_reg;
    bit_next    = bit_reg;
    cs_n_next   = cs_n_reg;
    sck_next    = sck_reg;
    sdi_next    = sdi_reg;
    ovr_next    = ovr_reg;

    if (wr_div) div_next = cpu_din;

    case (state_reg)
      IDLE: begin
        if (wr_data) begin
          sr_next     = cpu_din;
          sdi_next    = cpu_din[7];
          bit_next    = 3'd7;
          hc_next     = 8'h00;
          hp_div_next = div_eff;
          state_next  = LOW;
        end
        if (wr_ctrl) begin
          cs_n_next = cpu_din[0];
          if (cpu_din[6]) ovr_next = 1'b0;
        end
      end
      LOW: begin
        if (hc_reg == hp_div_reg) begin
          sck_next    = 1'b1;
          hc_next     = 8'h00;
          hp_div_next = div_eff;
          state_next  = HIGH;
        end else begin
          hc_next = hc_reg + 8'd1;
        end
      end
      HIGH: begin
        if (hc_reg == hp_div_reg) begin
          // MISO sampled in the last high cycle; old sr[6] becomes the next MOSI bit
          sr_next     = {sr_reg[6:0], sd_sdo};
          sck_next    = 1'b0;
          hc_next     = 8'h00;
          hp_div_next = div_eff;
          if (bit_reg == 3'd0) begin
            rx_next    = {sr_reg[6:0], sd_sdo};
            sdi_next   = 1'b1;
            state_next = IDLE;
          end else begin
            bit_next   = bit_reg - 3'd1;
            sdi_next   = sr_reg[6];
            state_next = LOW;
          end
        end else begin
          hc_next = hc_reg + 8'd1;
        end
      end
      default: state_next = IDLE;
    endcase

    if (busy && (wr_data || wr_ctrl)) ovr_next = 1'b1;
  end

  always_comb begin
    case (cpu_addr)
      2'd0:    cpu_dout = rx_reg;
      2'd1:    cpu_dout = {busy, ovr_reg, 5'b00000, cs_n_reg};
      2'd2:    cpu_dout = div_reg;
      default: cpu_dout = 8'hff;
    endcase
  end

  assign sd_cs  = cs_n_reg;
  assign sd_sck = sck_reg;
  assign sd_sdi = sdi_reg;

endmodule

// File: tb/tb_sd_spi_master.sv
// Directed/randomized bench for sd_spi_master with a loopback or byte-response SPI slave
// model; expectations come from the byte-level protocol rules (latency, pulses, data).
module tb_sd_spi_master;

  logic       clk_sys = 1'b0;
  logic       reset;
  logic       cpu_sel, cpu_we;
  logic [1:0] cpu_addr;
  logic [7:0] cpu_din;
  logic [7:0] cpu_dout;
  logic       sd_cs, sd_sck, sd_sdi, sd_sdo;

  sd_spi_master dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .cpu_sel (cpu_sel),
    .cpu_we  (cpu_we),
    .cpu_addr(cpu_addr),
    .cpu_din (cpu_din),
    .cpu_dout(cpu_dout),
    .sd_cs   (sd_cs),
    .sd_sck  (sd_sck),
    .sd_sdi  (sd_sdi),
    .sd_sdo  (sd_sdo)
  );

  always #5 clk_sys = ~clk_sys;

  int passed = 0;
  int total  = 0;

  // slave model state: loopback, or present resp MSB-first, advancing on each sck fall
  logic       loop;
  logic [7:0] resp;
  int         fall_base;
  int         falls = 0;
  int         rises = 0;
  int         hi_cnt = 0;
  int         viol = 0;
  logic [7:0] mosi = 8'h00;
  logic       prev_sck = 1'b0;
  logic       prev_sdi = 1'b1;
  int         idx;

  assign idx    = falls - fall_base;
  assign sd_sdo = loop ? sd_sdi : ((idx >= 0 && idx < 8) ? resp[3'(7 - idx)] : 1'b1);

  always @(negedge sd_sck) falls++;
  always @(posedge sd_sck) begin
    rises++;
    mosi = {mosi[6:0], sd_sdi};
  end

  // MOSI may only change while sck is low and stays low, or together with a falling sck
  always @(posedge clk_sys) begin
    #1;
    if (sd_sck) hi_cnt++;
    if ((sd_sdi !== prev_sdi) && !(prev_sck && !sd_sck) && !(!prev_sck && !sd_sck)) viol++;
    prev_sck = sd_sck;
    prev_sdi = sd_sdi;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk_sys);
    cpu_sel = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_din = d;
    @(posedge clk_sys);
    #1;
    cpu_sel = 1'b0; cpu_we = 1'b0;
    $display("write addr=%0d data=%02h", a, d);
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] d);
    cpu_addr = a;
    #1;
    d = cpu_dout;
  endtask

  // counts cycles from the write edge until STATUS.busy reads 0
  task automatic wait_idle(output int n);
    logic [7:0] st;
    n = 0;
    rd(2'd1, st);
    while (st[7] && n < 5000) begin
      @(posedge clk_sys);
      #1;
      n++;
      rd(2'd1, st);
    end
    if (n >= 5000) chk("busy_timeout", 32'(n), 32'd0);
  endtask

  task automatic xfer(input logic [7:0] tx, input logic [7:0] r, input int de, input string tag);
    int n, r0, h0;
    logic [7:0] d;
    resp = r;
    fall_base = falls;
    r0 = rises;
    h0 = hi_cnt;
    wr(2'd0, tx);
    wait_idle(n);
    rd(2'd0, d);
    chk({tag, "_cycles"}, 32'(n), 32'(16 * (de + 1)));
    chk({tag, "_pulses"}, 32'(rises - r0), 32'd8);
    chk({tag, "_hightime"}, 32'(hi_cnt - h0), 32'(8 * (de + 1)));
    chk({tag, "_mosi"}, {24'h0, mosi}, {24'h0, tx});
    chk({tag, "_rx"}, {24'h0, d}, {24'h0, loop ? tx : r});
    $display("xfer %s tx=%02h rx=%02h cycles=%0d", tag, tx, d, n);
  endtask

  initial begin
    logic [7:0] d, tx, r, lastrx;
    int dv, de, n, r0;

    reset = 1'b1; cpu_sel = 1'b0; cpu_we = 1'b0; cpu_addr = 2'd0; cpu_din = 8'h00;
    loop = 1'b1; resp = 8'hff; fall_base = 0;
    repeat (3) @(posedge clk_sys);
    #1 reset = 1'b0;

    chk("rst_cs", 32'(sd_cs), 32'd1);
    chk("rst_sck", 32'(sd_sck), 32'd0);
    chk("rst_sdi", 32'(sd_sdi), 32'd1);
    rd(2'd1, d); chk("rst_status", 32'(d), 32'h01);
    rd(2'd0, d); chk("rst_data", 32'(d), 32'hff);
    rd(2'd2, d); chk("rst_div", 32'(d), 32'h07);
    rd(2'd3, d); chk("rsvd_read", 32'(d), 32'hff);

    // loopback, default divider
    xfer(8'ha5, 8'h00, 7, "loop_a5");

    // randomized bytes against the response slave, random dividers (0..5 exercises clamping)
    loop = 1'b0;
    wr(2'd1, 8'h00);
    chk("cs_low", 32'(sd_cs), 32'd0);
    for (int i = 0; i < 6; i++) begin
      dv = int'($urandom_range(0, 5));
      de = (dv < 2) ? 2 : dv;
      tx = 8'($urandom);
      r  = 8'($urandom);
      wr(2'd2, 8'(dv));
      xfer(tx, r, de, "rand");
    end

    // divider 0 clamps to 2 but reads back as written
    wr(2'd2, 8'h00);
    rd(2'd2, d); chk("div0_read", 32'(d), 32'h00);
    loop = 1'b1;
    xfer(8'h3c, 8'h00, 2, "div0");
    lastrx = 8'h3c;

    // overrun: DATA/CTRL writes during a transfer are dropped and set ovr
    wr(2'd1, 8'h01);
    wr(2'd0, 8'h12);
    wr(2'd0, 8'h34);
    wr(2'd1, 8'h00);
    chk("ovr_cs_hold", 32'(sd_cs), 32'd1);
    rd(2'd1, d); chk("ovr_flag", 32'(d[6]), 32'd1);
    rd(2'd0, d); chk("rx_during_busy", 32'(d), 32'(lastrx));
    wait_idle(n);
    rd(2'd0, d); chk("ovr_rx", 32'(d), 32'h12);
    rd(2'd1, d); chk("ovr_sticky", 32'(d), 32'h41);
    wr(2'd1, 8'h41);
    rd(2'd1, d); chk("ovr_clear", 32'(d), 32'h01);
    chk("ovr_cs_after", 32'(sd_cs), 32'd1);

    // reset mid-transfer, with cs driven low first
    wr(2'd1, 8'h00);
    wr(2'd2, 8'h07);
    wr(2'd0, 8'h00);
    repeat (20) @(posedge clk_sys);
    @(negedge clk_sys);
    reset = 1'b1;
    @(posedge clk_sys);
    #1 reset = 1'b0;
    chk("midrst_cs", 32'(sd_cs), 32'd1);
    chk("midrst_sck", 32'(sd_sck), 32'd0);
    chk("midrst_sdi", 32'(sd_sdi), 32'd1);
    rd(2'd1, d); chk("midrst_status", 32'(d), 32'h01);
    rd(2'd0, d); chk("midrst_data", 32'(d), 32'hff);

    // idle: no clocks and MOSI held high
    r0 = rises;
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk_sys);
      #1;
      if (sd_sdi !== 1'b1 || sd_sck !== 1'b0) n++;
    end
    chk("idle_rises", 32'(rises - r0), 32'd0);
    chk("idle_lines", 32'(n), 32'd0);

    chk("mosi_timing", 32'(viol), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
